// File: rtl/recv_reg_axis.sv
// Two-wire LED serial bus receiver: oversamples led clk/data, shifts MSB-first 32-bit words,
// presents them on an AXI-Stream master. Define RECV_REG_AXIS_FIFO_EN for a 4-entry output FIFO.
module recv_reg_axis #(
    parameter int IDLE_TIMEOUT = 1024,
    parameter int TIMEOUT_W    = 11
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_led_clk,
    input  logic        i_led_data,
    output logic [31:0] m_axis_data,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        o_overflow,
    output logic        o_sync_err
);

    localparam logic [TIMEOUT_W-1:0] IDLE_MAX = TIMEOUT_W'(IDLE_TIMEOUT);

    logic                 clk_s1, clk_s2, clk_s3;
    logic                 data_s1, data_s2;
    logic [30:0]          sr;
    logic [4:0]           bit_cnt;
    logic [TIMEOUT_W-1:0] idle_cnt;
    logic                 rise;
    logic                 push;
    logic                 drop;
    logic                 pop;
    logic [31:0]          word;

    assign rise = clk_s2 & ~clk_s3;
    assign push = rise && (bit_cnt == 5'd31);
    assign word = {sr, data_s2};
    // AXIS handshake: a beat transfers on a clock edge where m_axis_tvalid and m_axis_tready
    // are both 1; tvalid comes from registers only, and data is held while valid and not ready.
    assign pop  = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            clk_s3  <= 1'b0;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            clk_s1  <= i_led_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= i_led_data;
            data_s2 <= data_s1;
        end
    end

    // A rise always wins over a timeout in the same cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sr         <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            o_sync_err <= 1'b0;
        end else if (rise) begin
            sr       <= {sr[29:0], data_s2};
            bit_cnt  <= bit_cnt + 5'd1;
            idle_cnt <= '0;
        end else if (idle_cnt == IDLE_MAX) begin
            if (bit_cnt != 5'd0) begin
                bit_cnt    <= '0;
                o_sync_err <= 1'b1;
            end
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end
    end

`ifdef RECV_REG_AXIS_FIFO_EN
    logic [31:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        full;
    logic        accept;

    assign full          = (count == 3'd4);
    assign accept        = push && (!full || pop);
    assign drop          = push && full && !pop;
    assign m_axis_tvalid = (count != 3'd0);
    assign m_axis_data   = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
`else
    assign drop = push && m_axis_tvalid && !pop;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_axis_data   <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (push && (!m_axis_tvalid || pop)) begin
            m_axis_data   <= word;
            m_axis_tvalid <= 1'b1;
        end else if (pop) begin
            m_axis_tvalid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_recv_reg_axis.sv
// Bench for recv_reg_axis: serial driver tasks, an expected-word queue checked on every beat,
// directed vectors, idle-timeout and reset sequences, and a random-tready streaming run.
module tb_recv_reg_axis;

`ifdef RECV_REG_AXIS_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        led_clk = 1'b0;
    logic        led_data = 1'b0;
    logic [31:0] data;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        overflow;
    logic        sync_err;

    int n_cmp = 0;
    int n_fail = 0;
    int beat_cnt = 0;
    logic [31:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    typedef struct {
        logic [31:0] word;
        int          stall;
        logic [31:0] exp_data;
    } vec_t;

    recv_reg_axis dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_led_clk     (led_clk),
        .i_led_data    (led_data),
        .m_axis_data   (data),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .o_overflow    (overflow),
        .o_sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the top nbits of word MSB-first; each bit is a 4-cycle low then 4-cycle high phase.
    task automatic send_bits(input logic [31:0] word, input int nbits);
        for (int i = 31; i > 31 - nbits; i--) begin
            led_clk  = 1'b0;
            led_data = word[i];
            cycles(4);
            led_clk = 1'b1;
            cycles(4);
        end
    endtask

    task automatic send_word(input logic [31:0] word);
        send_bits(word, 32);
        cycles(4);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycles(1);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected word, and a stalled
    // beat must keep both tvalid and data unchanged.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_tvalid", {31'd0, tvalid}, 32'd1);
                check("stall_data", data, prev_data);
            end
            if (tvalid && tready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%08h expected no beat at %0t", data, $time);
                end else begin
                    check("beat_data", data, exp_q.pop_front());
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = data;
        end
    end

    initial begin
        vec_t vecs[4];
        int   b0;
        bit   done;
        logic [31:0] base;

        vecs[0] = '{word: 32'h8000_0000, stall: 0,  exp_data: 32'h8000_0000};
        vecs[1] = '{word: 32'hFFFF_FFFF, stall: 20, exp_data: 32'hFFFF_FFFF};
        vecs[2] = '{word: 32'hA5C3_0F01, stall: 5,  exp_data: 32'hA5C3_0F01};
        vecs[3] = '{word: 32'h0000_0000, stall: 40, exp_data: 32'h0000_0000};

        // Reset values
        cycles(3);
        check("rst_data", data, 32'd0);
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_sync_err", {31'd0, sync_err}, 32'd0);
        rst_n = 1'b1;
        cycles(4);

        // Directed vectors, each delivered exactly once
        foreach (vecs[v]) begin
            b0 = beat_cnt;
            tready = (vecs[v].stall == 0);
            exp_q.push_back(vecs[v].exp_data);
            send_word(vecs[v].word);
            if (vecs[v].stall != 0) begin
                check("vec_tvalid", {31'd0, tvalid}, 32'd1);
                check("vec_data", data, vecs[v].exp_data);
                cycles(vecs[v].stall);
                check("vec_data_held", data, vecs[v].exp_data);
                tready = 1'b1;
            end
            wait_drain(50);
            cycles(10);
            check("vec_beats", 32'(beat_cnt - b0), 32'd1);
            check("vec_tvalid_idle", {31'd0, tvalid}, 32'd0);
            check("vec_overflow", {31'd0, overflow}, 32'd0);
            check("vec_sync_err", {31'd0, sync_err}, 32'd0);
        end

        // Two words while stalled
        b0 = beat_cnt;
        tready = 1'b0;
        exp_q.push_back(32'h0000_0001);
        if (FIFO_EN) exp_q.push_back(32'h0000_0002);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        check("ovf_data", data, 32'h0000_0001);
        check("ovf_flag", {31'd0, overflow}, FIFO_EN ? 32'd0 : 32'd1);
        cycles(3);
        tready = 1'b1;
        wait_drain(50);
        cycles(10);
        check("ovf_beats", 32'(beat_cnt - b0), FIFO_EN ? 32'd2 : 32'd1);
        check("ovf_tvalid_idle", {31'd0, tvalid}, 32'd0);

        // Partial word abandoned by idle timeout
        b0 = beat_cnt;
        send_bits(32'h1234_5678, 16);
        check("idle_pre_err", {31'd0, sync_err}, 32'd0);
        cycles(1100);
        check("idle_err", {31'd0, sync_err}, 32'd1);
        exp_q.push_back(32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        wait_drain(50);
        cycles(10);
        check("idle_beats", 32'(beat_cnt - b0), 32'd1);

        // Reset mid-word with a pending beat and sticky flags set
        tready = 1'b0;
        exp_q.push_back(32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        send_bits(32'hFFFF_FFFF, 10);
        led_clk = 1'b0;
        cycles(4);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data, 32'd0);
        check("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("mid_rst_sync_err", {31'd0, sync_err}, 32'd0);
        check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        exp_q.delete();
        cycles(3);
        rst_n = 1'b1;
        tready = 1'b1;
        cycles(3);
        b0 = beat_cnt;
        exp_q.push_back(32'h1234_5678);
        send_word(32'h1234_5678);
        wait_drain(50);
        cycles(10);
        check("post_rst_beats", 32'(beat_cnt - b0), 32'd1);

        // 64 incrementing words from a random base with random tready
        b0 = beat_cnt;
        base = $urandom;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    exp_q.push_back(base + 32'(i));
                    send_bits(base + 32'(i), 32);
                end
                cycles(4);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tready = 1'($urandom_range(0, 1));
                    cycles(1);
                end
            end
        join
        tready = 1'b1;
        wait_drain(100);
        check("rand_beats", 32'(beat_cnt - b0), 32'd64);
        check("rand_overflow", {31'd0, overflow}, 32'd0);
        check("rand_sync_err", {31'd0, sync_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
